// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset causes and a
// counter-width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    POR = 2'd0,
    SW  = 2'd1,
    WDT = 2'd2
  } cause_t;

  // Bits needed to count 0 .. maxVal-1.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal);
  endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog counter for the reset sequencer; raises expire while the running
// count equals the programmed limit.
module rst_seq_wdt #(
  parameter int WDT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wdt_kick,
  input  logic [WDT_W-1:0] wdt_limit,
  output logic             expire
);

  logic [WDT_W-1:0] cnt_q;
  logic [WDT_W-1:0] cnt_d;

  // A kick beats the increment; dropping the enable also clears the count.
  always_comb begin
    cnt_d = cnt_q + WDT_W'(1);
    if (!en || wdt_kick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == wdt_limit);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all domains in reset, releases them in
// ascending order, and restarts on software request or watchdog expiry.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST  = 4,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8,
  parameter int WDT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  input  logic               wdt_en,
  input  logic               wdt_kick,
  input  logic [WDT_W-1:0]   wdt_limit,
  output logic [NUM_RST-1:0] rst_out,
  output logic               all_rel,
  output logic               busy,
  output logic [1:0]         rst_cause
);

  localparam int CNT_MAX = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
  localparam int CNT_W   = cntWidth(CNT_MAX);
  localparam int IDX_W   = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_RST-1:0]   rstOut_q, rstOut_d;
  cause_t               cause_q, cause_d;
  logic                 ack_q, ack_d;
  logic                 armed_q, armed_d;

  logic                 swAccept;
  logic                 wdtCntEn;
  logic                 wdtExpire;

  assign wdtCntEn = (state_q == RUN) && wdt_en && (wdt_limit != '0);
  assign swAccept = (state_q == RUN) && sw_rst_req && armed_q;

  rst_seq_wdt #(
    .WDT_W(WDT_W)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .en       (wdtCntEn),
    .wdt_kick (wdt_kick),
    .wdt_limit(wdt_limit),
    .expire   (wdtExpire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rstOut_q <= '1;
      cause_q  <= POR;
      ack_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rstOut_q <= rstOut_d;
      cause_q  <= cause_d;
      ack_q    <= ack_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rstOut_d = rstOut_q;
    cause_d  = cause_q;
    ack_d    = 1'b0;
    armed_d  = armed_q || !sw_rst_req;

    case (state_q)
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          rstOut_d[0] = 1'b0;
          cnt_d       = '0;
          idx_d       = IDX_W'(1);
          state_d     = (NUM_RST == 1) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
          rstOut_d[idx_q] = 1'b0;
          cnt_d           = '0;
          if (idx_q == IDX_W'(NUM_RST - 1)) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        rstOut_d = '0;
        cnt_d    = '0;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // When both triggers land together the watchdog owns the recorded cause.
    if (swAccept) begin
      ack_d    = 1'b1;
      armed_d  = 1'b0;
      cause_d  = SW;
    end
    if (wdtExpire) begin
      cause_d = WDT;
    end
    if (swAccept || wdtExpire) begin
      state_d  = HOLD;
      cnt_d    = '0;
      idx_d    = '0;
      rstOut_d = '1;
    end
  end

  always_comb begin
    all_rel    = (state_q == RUN);
    busy       = (state_q != RUN);
    rst_out    = rstOut_q;
    sw_rst_ack = ack_q;
    rst_cause  = cause_q;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed scoreboard bench for rst_seq_ctrl: POR, software request,
// watchdog, collision and mid-sequence reset.
module tb_rst_seq_ctrl;

  localparam int NUM_RST  = 4;
  localparam int HOLD_CYC = 16;
  localparam int STEP_CYC = 8;
  localparam int WDT_W    = 16;
  localparam int SEQ_LEN  = HOLD_CYC + (NUM_RST - 1) * STEP_CYC;

  typedef struct packed {
    logic [NUM_RST-1:0] rstOut;
    logic               allRel;
    logic               busy;
    logic               ack;
    logic [1:0]         cause;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               swRstReq;
  logic               swRstAck;
  logic               wdtEn;
  logic               wdtKick;
  logic [WDT_W-1:0]   wdtLimit;
  logic [NUM_RST-1:0] rstOut;
  logic               allRel;
  logic               busy;
  logic [1:0]         rstCause;

  exp_t  sbQ[$];
  string tagQ[$];
  int    total = 0;
  int    bad   = 0;

  rst_seq_ctrl #(
    .NUM_RST (NUM_RST),
    .HOLD_CYC(HOLD_CYC),
    .STEP_CYC(STEP_CYC),
    .WDT_W   (WDT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(swRstReq),
    .sw_rst_ack(swRstAck),
    .wdt_en    (wdtEn),
    .wdt_kick  (wdtKick),
    .wdt_limit (wdtLimit),
    .rst_out   (rstOut),
    .all_rel   (allRel),
    .busy      (busy),
    .rst_cause (rstCause)
  );

  always #5 clk = ~clk;

  // Expected outputs k edges into a sequence (k=0 is the edge that forced all ones).
  function automatic exp_t seqExp(input int k, input logic [1:0] cause, input logic ack);
    exp_t e;
    for (int i = 0; i < NUM_RST; i++) begin
      e.rstOut[i] = (k < HOLD_CYC + i * STEP_CYC);
    end
    e.allRel = (k >= SEQ_LEN);
    e.busy   = (k < SEQ_LEN);
    e.ack    = ack;
    e.cause  = cause;
    return e;
  endfunction

  // Queue what the DUT must show after the coming edge, then let that edge happen.
  task automatic applyStimulus(input string tag, input exp_t e);
    sbQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    total++;
    assert (sbQ.size() > 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_empty: got size=%0d exp size>0", sbQ.size());
    end
    if (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      tag = tagQ.pop_front();
      total++;
      assert (rstOut === e.rstOut) else begin
        bad++;
        $error("[TB] FAIL %s rst_out: got=%h exp=%h", tag, rstOut, e.rstOut);
      end
      total++;
      assert (allRel === e.allRel) else begin
        bad++;
        $error("[TB] FAIL %s all_rel: got=%b exp=%b", tag, allRel, e.allRel);
      end
      total++;
      assert (busy === e.busy) else begin
        bad++;
        $error("[TB] FAIL %s busy: got=%b exp=%b", tag, busy, e.busy);
      end
      total++;
      assert (swRstAck === e.ack) else begin
        bad++;
        $error("[TB] FAIL %s sw_rst_ack: got=%b exp=%b", tag, swRstAck, e.ack);
      end
      total++;
      assert (rstCause === e.cause) else begin
        bad++;
        $error("[TB] FAIL %s rst_cause: got=%0d exp=%0d", tag, rstCause, e.cause);
      end
    end
  endtask

  task automatic stepCheck(input string tag, input exp_t e);
    applyStimulus(tag, e);
    checkOutput();
  endtask

  task automatic runSequence(input string tag, input logic [1:0] cause,
                             input int fromK, input int toK);
    for (int k = fromK; k <= toK; k++) begin
      stepCheck(tag, seqExp(k, cause, 1'b0));
    end
  endtask

  initial begin
    rst      = 1'b1;
    swRstReq = 1'b0;
    wdtEn    = 1'b0;
    wdtKick  = 1'b0;
    wdtLimit = '0;

    // Power-on reset and the first full release sequence.
    for (int i = 0; i < 3; i++) stepCheck("por_reset", seqExp(0, 2'd0, 1'b0));
    rst = 1'b0;
    runSequence("por_seq", 2'd0, 1, SEQ_LEN);
    runSequence("por_run", 2'd0, SEQ_LEN + 1, SEQ_LEN + 4);

    // Level request held high: one ack, one sequence, then no re-accept.
    swRstReq = 1'b1;
    stepCheck("sw_ack", seqExp(0, 2'd1, 1'b1));
    runSequence("sw_seq", 2'd1, 1, SEQ_LEN);
    runSequence("sw_held", 2'd1, SEQ_LEN + 1, 99);
    swRstReq = 1'b0;
    stepCheck("sw_drop", seqExp(SEQ_LEN + 1, 2'd1, 1'b0));
    swRstReq = 1'b1;
    stepCheck("sw_ack2", seqExp(0, 2'd1, 1'b1));
    swRstReq = 1'b0;

    // Watchdog armed during the sequence only counts once RUN is reached.
    wdtEn    = 1'b1;
    wdtLimit = WDT_W'(10);
    runSequence("sw2_seq", 2'd1, 1, SEQ_LEN);
    runSequence("wdt_count", 2'd1, SEQ_LEN + 1, SEQ_LEN + 10);
    stepCheck("wdt_expire", seqExp(0, 2'd2, 1'b0));
    runSequence("wdt_seq", 2'd2, 1, SEQ_LEN);

    for (int j = 0; j < 200; j++) begin
      wdtKick = ((j % 5) == 4);
      stepCheck("wdt_kicked", seqExp(SEQ_LEN + 1, 2'd2, 1'b0));
    end
    wdtKick = 1'b0;

    // Count reaches the limit exactly when the software request arrives.
    runSequence("coll_pre", 2'd2, SEQ_LEN + 1, SEQ_LEN + 10);
    swRstReq = 1'b1;
    stepCheck("coll_ack", seqExp(0, 2'd2, 1'b1));
    swRstReq = 1'b0;
    wdtEn    = 1'b0;
    runSequence("coll_seq", 2'd2, 1, SEQ_LEN);
    runSequence("coll_run", 2'd2, SEQ_LEN + 1, SEQ_LEN + 5);

    // Synchronous reset part-way through release (rst_out = 4'hC).
    swRstReq = 1'b1;
    stepCheck("mid_ack", seqExp(0, 2'd1, 1'b1));
    swRstReq = 1'b0;
    runSequence("mid_seq", 2'd1, 1, HOLD_CYC + STEP_CYC);
    rst = 1'b1;
    stepCheck("mid_reset", seqExp(0, 2'd0, 1'b0));
    rst = 1'b0;
    runSequence("mid_replay", 2'd0, 1, SEQ_LEN);
    runSequence("mid_run", 2'd0, SEQ_LEN + 1, SEQ_LEN + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that drives the staged reset inputs of `top` and every other block in the design. It holds all reset domains asserted for a minimum hold time, then releases them one at a time in a fixed order. It also re-enters that sequence on a software reset request (req/ack handshake) or on a watchdog expiry, and records the cause of the last reset.

## Interface
Parameters:
- `NUM_RST`, default 4: number of reset domains driven.
- `HOLD_CYC`, default 16: cycles all domains stay asserted before the first release; ≥1.
- `STEP_CYC`, default 8: cycles between successive domain releases; ≥1.
- `WDT_W`, default 16: watchdog counter and limit width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `sw_rst_req` in 1: software reset request, level.
- `sw_rst_ack` out 1: one-cycle pulse when a request is accepted.
- `wdt_en` in 1: watchdog enable.
- `wdt_kick` in 1: clears the watchdog count.
- `wdt_limit` in `WDT_W`: expiry count; 0 disables the watchdog.
- `rst_out` out `NUM_RST`: active-high domain resets, released in order bit 0 first.
- `all_rel` out 1: high only when every domain is released (state RUN).
- `busy` out 1: high in HOLD and RELEASE.
- `rst_cause` out 2: cause of the last reset; 0 = POR, 1 = SW, 2 = WDT, 3 = reserved.

## Operation
- States: HOLD, RELEASE, RUN.
- Reset values while `rst`=1:
  - state HOLD, counters 0.
  - `rst_out` all ones, `all_rel`=0, `busy`=1.
  - `sw_rst_ack`=0, `rst_cause`=0.
  - watchdog count 0, SW arm flag 0.
- `rst` has priority over everything, in any state.
- HOLD:
  - count cycles; at count `HOLD_CYC` clear `rst_out[0]`.
  - go to RELEASE, or to RUN if `NUM_RST`=1.
- RELEASE:
  - every `STEP_CYC` cycles clear the next `rst_out` bit, ascending.
  - clearing bit `NUM_RST-1` enters RUN.
  - bits never re-assert during RELEASE.
- RUN:
  - `all_rel`=1, `busy`=0, `rst_out`=0.
- SW arm flag:
  - sets in any cycle `sw_rst_req`=0; clears on accept.
  - a request held high across a sequence is not re-accepted.
- SW accept: `sw_rst_req`=1 while in RUN with arm=1.
  - next edge: `sw_rst_ack`=1 for one cycle, `rst_out` all ones, `rst_cause`=1, state HOLD.
- Watchdog: counts only in RUN with `wdt_en`=1 and `wdt_limit`≠0.
  - `wdt_kick`=1 forces the count to 0 that cycle, taking precedence over increment.
  - when the count equals `wdt_limit`: next edge `rst_out` all ones, `rst_cause`=2, state HOLD.
  - the count clears outside RUN or when `wdt_en`=0.
- SW accept and WDT expiry in the same cycle: both are taken; `sw_rst_ack` pulses and `rst_cause`=2.
- `wdt_limit` changes take effect immediately; a limit below the current count expires only after wrap-around at 2^`WDT_W`.

## Timing
- First edge with `rst` sampled low = cycle 1 of HOLD.
- `rst_out[0]` falls at the end of cycle `HOLD_CYC`.
- `rst_out[i]` falls `STEP_CYC` cycles after `rst_out[i-1]`.
- `all_rel` rises and `busy` falls on the same edge that clears `rst_out[NUM_RST-1]`.
- Total sequence length: `HOLD_CYC + (NUM_RST-1)*STEP_CYC` cycles; 40 with defaults.
- SW or WDT trigger: one cycle from the sampled condition to `rst_out` all ones; the hold count then restarts from 1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `rst_seq_pkg`:
  - `state_t` enum (HOLD, RELEASE, RUN).
  - `cause_t` enum (POR=0, SW=1, WDT=2).
- Sub-module `rst_seq_wdt`:
  - contains the watchdog counter and its compare.
  - inputs: `clk`, `rst`, count enable, `wdt_kick`, `wdt_limit`.
  - output: a one-cycle `expire` pulse.
- The top-level FSM holds the hold/step counters, the `rst_out` register, the arm flag and the cause.

## Test plan
- POR: `rst` high 3 cycles, then low → `rst_out` 4'hF for 16 cycles, then 4'hE, 4'hC, 4'h8, 4'h0 at 8-cycle steps; `all_rel` rises at cycle 40; `rst_cause`=0.
- SW request: in RUN, hold `sw_rst_req` high 100 cycles → exactly one `sw_rst_ack` pulse; full 40-cycle re-sequence; `rst_cause`=1; no second reset. Drop `req` 1 cycle, raise again → second ack.
- Watchdog: `wdt_en`=1, `wdt_limit`=10, no kick → reset asserts 11 cycles after RUN entry; `rst_cause`=2. Kicks every 5 cycles for 200 cycles → no reset.
- Collision: SW accept and WDT expiry in the same cycle → ack pulses, `rst_cause`=2, a single sequence.
- Mid-sequence reset: assert `rst` when `rst_out`=4'hC → next edge 4'hF, `rst_cause`=0, the full 40-cycle sequence replays.
